// File: rtl/fifo8_burst_reader.sv
// Burst read controller for FIFO_8: mirrors occupancy from the writer's wen and streams len bytes downstream.
// Optional stall abort is enabled by defining READER_TIMEOUT_EN.
module fifo8_burst_reader #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_seen,
  input  logic             start,
  input  logic [3:0]       len,
  output logic             fifo_ren,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_error,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             rd_err,
  output logic             timeout
);

  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [OCC_W-1:0] occ;
  logic [3:0]       remaining;
  // [0]: FIFO data/error valid this cycle, [1]: captured byte presented downstream
  logic [STAGES:0]  vld_pipe;

  logic       accept;
  logic       rd_bad;
  logic       last_rd;
  logic       to_hit;
  logic [3:0] len_clamp;

  assign accept    = (state == IDLE) & start;
  assign rd_bad    = vld_pipe[0] & fifo_error;
  assign len_clamp = (len > 4'd8) ? 4'd8 : len;
  assign fifo_ren  = (state == RUN) & (remaining != 4'd0) & (occ != '0);
  assign last_rd   = fifo_ren & (remaining == 4'd1);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = vld_pipe[STAGES];

`ifdef READER_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT + 1);

  logic [ST_W-1:0] stall_cnt;
  logic            stall;

  assign stall  = (state == RUN) & (remaining != 4'd0) & (occ == '0);
  assign to_hit = stall & (stall_cnt == ST_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      if (stall && !to_hit) stall_cnt <= stall_cnt + ST_W'(1);
      else                  stall_cnt <= '0;
      if (accept)      timeout <= 1'b0;
      else if (to_hit) timeout <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == 4'd0) ? DONE : RUN;
      RUN: begin
        if (last_rd)     state_nxt = DRAIN;
        else if (to_hit) state_nxt = DONE;
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      occ       <= '0;
      remaining <= 4'd0;
      vld_pipe  <= '0;
      out_data  <= '0;
      rd_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[0] & ~fifo_error, fifo_ren};
      if (vld_pipe[0] && !fifo_error) out_data <= fifo_dout;

      // A FIFO error means our mirror is out of step with the buffer; resync to empty.
      if (rd_bad)                                     occ <= '0;
      else if (fifo_ren)                              occ <= occ - OCC_W'(1);
      else if (wr_seen && (occ < OCC_W'(DEPTH)))      occ <= occ + OCC_W'(1);

      if (accept)        remaining <= len_clamp;
      else if (fifo_ren) remaining <= remaining - 4'd1;
      else if (to_hit)   remaining <= 4'd0;

      if (accept)      rd_err <= 1'b0;
      if (rd_bad)      rd_err <= 1'b1;
    end
  end

endmodule
